// File: rtl/uart_pkg.sv
// Shared UART definitions used by both uart_rx and uart_tx: receiver state
// encoding, default bit period and data width.
package uart_pkg;

    // Default bit period in clk_48 cycles (48 MHz / 48 = 1 Mbaud).
    localparam int UART_CLKS_PER_BIT_DEFAULT = 48;

    // Data bits per frame, LSB first on the wire.
    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs. RESET_VAL sets the
// value both stages take during reset, so an idle-high line comes out of
// reset already idle and does not produce a false edge.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_48,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] q_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
        end
    end

    assign q_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Byte-wide UART receiver, 8N1 by default. Define UART_RX_PARITY_EN to
// receive 8E1 frames (start, 8 data, even parity, stop) with a live
// parity_error output; it must match the setting used for uart_tx.
// Bits are sampled at their centre by a down-counter that is started half a
// bit after the falling start edge and reloaded with a full bit period.
module uart_rx
    import uart_pkg::*;
#(
    // clk_48 cycles per bit; must be at least 4 and even.
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk_48,
    input  logic                      reset,
    input  logic                      serial,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      data_strobe,
    output logic                      frame_error,
    output logic                      parity_error,
    output logic                      busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                BITN_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BITN_W-1:0] LAST_BIT  = BITN_W'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_e                 state_q,        state_d;
    logic [CNT_W-1:0]          cnt_q,          cnt_d;
    logic [BITN_W-1:0]         bitn_q,         bitn_d;
    logic [UART_DATA_BITS-1:0] sr_q,           sr_d;
    logic [UART_DATA_BITS-1:0] data_q,         data_d;
    logic                      rx_prev_q;
    logic                      data_strobe_q,  data_strobe_d;
    logic                      frame_error_q,  frame_error_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_ok_q,       par_ok_d;
    logic                      parity_error_q, parity_error_d;
`endif

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_48  (clk_48),
        .reset   (reset),
        .d_async (serial),
        .q_sync  (rx_s)
    );

    // Next-state, bit timing, shift register and one-cycle event pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (state_q == RX_IDLE) ? cnt_q : cnt_q - CNT_W'(1);
        bitn_d        = bitn_q;
        sr_d          = sr_q;
        data_d        = data_q;
        data_strobe_d = 1'b0;
        frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d       = par_ok_q;
        parity_error_d = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                // Falling edge: aim the first check at the middle of start.
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_d   = FULL_LOAD;
                        bitn_d  = '0;
                        state_d = RX_DATA;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    sr_d   = {rx_s, sr_q[UART_DATA_BITS-1:1]};
                    cnt_d  = FULL_LOAD;
                    bitn_d = bitn_q + BITN_W'(1);
                    if (bitn_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    par_ok_d = ((^sr_q) ^ rx_s) == 1'b0;
                    cnt_d    = FULL_LOAD;
                    state_d  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        // Leave at mid-stop so a start half a bit later is caught.
                        data_d        = sr_q;
                        data_strobe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_error_d = !par_ok_q;
`endif
                        state_d = RX_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Wait out a held-low line before looking for a new start.
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bitn_q        <= '0;
            sr_q          <= '0;
            data_q        <= '0;
            rx_prev_q     <= 1'b1;
            data_strobe_q <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q       <= 1'b1;
            parity_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitn_q        <= bitn_d;
            sr_q          <= sr_d;
            data_q        <= data_d;
            rx_prev_q     <= rx_s;
            data_strobe_q <= data_strobe_d;
            frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q       <= par_ok_d;
            parity_error_q <= parity_error_d;
`endif
        end
    end

    assign data        = data_q;
    assign data_strobe = data_strobe_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. Frames are driven on the serial pin at the nominal
// bit rate; each frame pushes its expected outcome (byte, error kind, cycle
// of the pulse) into a scoreboard that a separate monitor checks against
// the DUT's pulses. Compile with UART_RX_PARITY_EN to match an 8E1 build.
module tb_uart_rx;

    localparam int CPB = 48;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Pin edge -> pulse: 2 synchronizer flops + 1 edge-detect cycle to T0,
    // then half a bit to mid-start, then (NBITS-1) bits to mid-stop.
    localparam int LATENCY = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk_48 = 1'b0;
    logic       reset  = 1'b1;
    logic       serial = 1'b1;
    logic [7:0] data;
    logic       data_strobe;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    typedef struct {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         cyc       = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_48       (clk_48),
        .reset        (reset),
        .serial       (serial),
        .data         (data),
        .data_strobe  (data_strobe),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .busy         (busy)
    );

    always #5 clk_48 = ~clk_48;

    // Posedge counter used as the time base for expected pulse cycles.
    always @(posedge clk_48) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        exp_t e;
        e.ferr = 1'b0;
        e.perr = bad_par;
        e.data = b;
        e.due  = cyc + LATENCY;
        sb.push_back(e);
        last_good = b;
        serial = 1'b0;
        repeat (CPB) @(negedge clk_48);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            repeat (CPB) @(negedge clk_48);
        end
`ifdef UART_RX_PARITY_EN
        serial = (^b) ^ bad_par;
        repeat (CPB) @(negedge clk_48);
`endif
        serial = 1'b1;
        repeat (CPB) @(negedge clk_48);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_48);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_48) begin
        if (data_strobe || frame_error || parity_error) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {29'd0, data_strobe, frame_error, parity_error}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rx event cycle %0d: strobe=%0b ferr=%0b perr=%0b data=0x%02h (want ferr=%0b perr=%0b data=0x%02h due=%0d)",
                         cyc, data_strobe, frame_error, parity_error, data, e.ferr, e.perr, e.data, e.due);
                check("data_strobe", {31'd0, data_strobe}, {31'd0, !e.ferr});
                check("frame_error", {31'd0, frame_error}, {31'd0, e.ferr});
                check("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
                check("data", {24'd0, data}, {24'd0, e.data});
                check("pulse_cycle", cyc, e.due);
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        repeat (90000) @(posedge clk_48);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_cnt;
        exp_t e;

        // Reset state.
        idle(4);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_strobe", {31'd0, data_strobe}, 32'd0);
        check("reset_ferr", {31'd0, frame_error}, 32'd0);
        check("reset_perr", {31'd0, parity_error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(2 * CPB);

        // Single 0x55, busy drops once the frame is done.
        send_frame(8'h55, 1'b0);
        check("busy_after_55", {31'd0, busy}, 32'd0);
        idle(CPB);

        // Back-to-back 0x00 then 0xFF, one stop bit between them.
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        idle(2 * CPB);

        // 10-cycle glitch: START for half a bit then back to IDLE.
        busy_cnt = 0;
        serial = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_48);
            if (busy) busy_cnt++;
        end
        serial = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_48);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, CPB / 2);
        send_frame(8'hA3, 1'b0);
        idle(CPB);

        // Break: line low for 20 bit times.
        e.ferr = 1'b1;
        e.perr = 1'b0;
        e.data = last_good;
        e.due  = cyc + LATENCY;
        sb.push_back(e);
        serial = 1'b0;
        idle(19 * CPB);
        check("busy_in_break", {31'd0, busy}, 32'd1);
        idle(CPB);
        serial = 1'b1;
        idle(2 * CPB);
        check("busy_after_break", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b0);
        idle(CPB);

        // Reset after bit 3 of 0x81: partial frame dropped, outputs cleared.
        serial = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            serial = (i == 0) ? 1'b1 : 1'b0;
            idle(CPB);
        end
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        serial = 1'b1;
        reset  = 1'b1;
        idle(3);
        check("mid_reset_data", {24'd0, data}, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_strobe", {31'd0, data_strobe}, 32'd0);
        reset     = 1'b0;
        last_good = 8'h00;
        idle(2 * CPB);
        send_frame(8'h81, 1'b0);
        idle(CPB);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is good, 0 is bad.
        send_frame(8'h07, 1'b0);
        idle(CPB);
        send_frame(8'h07, 1'b1);
        idle(CPB);
`endif

        // Random bytes with random gaps, including back-to-back frames.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            bit         bp;
            b  = 8'($urandom_range(0, 255));
            bp = 1'b0;
`ifdef UART_RX_PARITY_EN
            bp = ($urandom_range(0, 3) == 0);
`endif
            send_frame(b, bp);
            if ($urandom_range(0, 3) != 0) begin
                idle($urandom_range(1, 3 * CPB));
            end
        end

        // Drain: every expected pulse must have arrived.
        for (int i = 0; i < 4 * CPB && sb.size() != 0; i++) begin
            @(negedge clk_48);
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver, 8N1 (optionally 8E1), the receive-side counterpart of the existing `uart_tx`. Samples `serial_rxd` from the host bridge in the `clk_48` domain, recovers bit timing from an internal divider, and presents each good byte as a one-cycle strobe. It sits beside `uart_tx` in the top level and feeds host commands, such as capsense threshold or rate updates, into the design.

## Interface
- `CLKS_PER_BIT`, default 48: `clk_48` cycles per bit (48 = 1 Mbaud). Must be ≥ 4 and even.
- `clk_48`  in  1  system clock, 48 MHz.
- `reset`  in  1  synchronous, active-high; clock `clk_48`.
- `serial`  in  1  asynchronous RX line, idle high.
- `data`  out  8  last good byte, LSB received first; reset 0x00.
- `data_strobe`  out  1  one-cycle pulse, `data` valid this cycle and after; reset 0.
- `frame_error`  out  1  one-cycle pulse, stop bit sampled low; reset 0.
- `parity_error`  out  1  one-cycle pulse when `UART_RX_PARITY_EN` is defined, else constant 0; reset 0.
- `busy`  out  1  high in every state except IDLE; reset 0.

## Operation
- `serial` passes through a 2-flop synchronizer (flops reset to 1), giving `rx_s`. A third flop holds the previous `rx_s` for edge detection.
- Down-counter `cnt`, width $clog2(CLKS_PER_BIT). It decrements every cycle outside IDLE. Each state acts when `cnt == 0`.
- States and transitions:
  - IDLE: on `rx_s` 1→0, load `cnt = CLKS_PER_BIT/2 - 1` and go to START.
  - START: at `cnt == 0`, if `rx_s == 0`, load `CLKS_PER_BIT - 1`, clear `bitn`, and go to DATA. If `rx_s == 1`, it is a false start: go to IDLE with no output.
  - DATA: at `cnt == 0`, shift `rx_s` into bit 7 of shift register `sr` (right shift), reload, increment `bitn`. After `bitn == 7` go to PARITY (macro defined) or STOP.
  - PARITY: at `cnt == 0`, latch `par_ok = (^sr ^ rx_s) == 0` (even parity), reload, and go to STOP.
  - STOP: at `cnt == 0`:
    - `rx_s == 1`: `data <= sr`, pulse `data_strobe`. Also pulse `parity_error` when `!par_ok`; in that case `data` is still updated and `data_strobe` still pulses. Go to IDLE.
    - `rx_s == 0`: pulse `frame_error`, leave `data` unchanged, no `data_strobe`. Go to BREAK.
  - BREAK: wait until `rx_s == 1`, then go to IDLE. No new start is detected while the line is held low.
- Returning to IDLE at mid-stop-bit is deliberate: it allows a following start edge half a bit later to be caught.
- No receive FIFO and no overrun detection. The consumer must take `data` before the next strobe, at least 9 bit times later.
- `reset` asserted in any state forces IDLE, clears all outputs, and sets the synchronizer to 1. Any partial frame is discarded.

## Timing
- T0 is the first cycle in which `rx_s` is seen low in IDLE. T0 is 2 to 3 cycles after the pin edge.
- START check at T0 + CLKS_PER_BIT/2.
- Data bit k sampled at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sampled at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (+1 bit with parity).
- `data_strobe`, `frame_error` and `parity_error` are registered and assert the cycle after the stop sample: T0+457 for the default 8N1 case.
- All pulses last exactly one cycle. `data_strobe` and `frame_error` are mutually exclusive.
- Tolerates roughly ±4% baud mismatch over a 10-bit frame.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is start + 8 data + even parity + stop. PARITY state is present and `parity_error` is live.
  - Undefined: 8N1, PARITY state removed, `parity_error` tied 0.
  - Pair it with the same setting on `uart_tx`.

## Structure
- Shared package `uart_pkg`, also used by `uart_tx`, holds:
  - state encoding constants `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PARITY`, `RX_STOP`, `RX_BREAK`
  - the default `CLKS_PER_BIT`
  - `UART_DATA_BITS = 8`
- One sub-module: `sync_2ff`, a generic 2-flop synchronizer with a reset-value parameter, reused for other async inputs.

## Test plan
- 8N1 0x55 at CLKS_PER_BIT=48 → `data = 0x55` with a single `data_strobe` at T0+457; `busy` low one cycle later.
- Back-to-back 0x00 then 0xFF with one stop bit each → two strobes exactly 480 cycles apart, `data` 0x00 then 0xFF, no errors.
- 10-cycle low glitch on an idle line → no strobe, no error, `busy` pulses for 24 cycles. A real 0xA3 sent immediately after is received correctly.
- Line held low for 20 bit times (break) → one `frame_error`, no `data_strobe`, `data` unchanged, state held in BREAK until high. The next 0x3C is received correctly.
- `reset` asserted mid-frame (after bit 3 of 0x81) → outputs 0 and no strobe. The line idles, and the next 0x81 produces `data = 0x81`.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 → strobe, no `parity_error`.
  - Parity bit 0 → strobe with `data = 0x07` and a coincident `parity_error`.
